// File: rtl/bus_bridge_pkg.sv
// Shared definitions for both ends of the UART bus bridge.
// Frame layout: {mode, wdata, addr}, with addr in the low bits.
// Helper functions give the frame width and mode bit for any bus widths.
package bus_bridge_pkg;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RDY,
    ST_ADDR,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_UTX
  } bb_state_e;

  // Total frame width: address, write data, then one mode bit on top.
  function automatic int frame_width(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

  // Position of the mode bit; it is always the frame MSB.
  function automatic int mode_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/uart.sv
// Minimal UART: 8N1-style frames (start, data LSB first, stop) of configurable widths.
// Latency: tx starts the cycle after data_en is accepted; rx_ready pulses in the stop bit.
// Backpressure: data_en is ignored while tx_busy is high; the receiver cannot be stalled.
module uart #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int TX_DATA_WIDTH    = 8,
  parameter int RX_DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     data_en,
  input  logic [TX_DATA_WIDTH-1:0] tx_data,
  output logic                     tx_busy,
  output logic                     tx,
  input  logic                     rx,
  output logic [RX_DATA_WIDTH-1:0] rx_data,
  output logic                     rx_ready
);

  localparam int CW   = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int TBW  = $clog2(TX_DATA_WIDTH + 3);
  localparam int RBW  = $clog2(RX_DATA_WIDTH + 3);
  // Start-bit delay so samples land mid-bit, allowing for the two-flop synchroniser.
  localparam int HALF = (CLOCKS_PER_PULSE / 2 > 2) ? CLOCKS_PER_PULSE / 2 - 2 : 0;

  logic [TX_DATA_WIDTH+1:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0]            tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [TBW-1:0]           tx_bits_q, tx_bits_d;
  logic [RBW-1:0]           rx_bits_q, rx_bits_d;
  logic                     tx_busy_q, tx_busy_d, rx_act_q, rx_act_d, rx_ready_q, rx_ready_d;
  logic [RX_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]               rx_sync_q, rx_sync_d;
  logic                     rx_s;

  assign rx_s     = rx_sync_q[1];
  assign tx       = tx_shift_q[0];
  assign tx_busy  = tx_busy_q;
  assign rx_data  = rx_shift_q;
  assign rx_ready = rx_ready_q;

  // Transmitter: load {stop, data, start} and shift one bit per pulse period.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_busy_d  = tx_busy_q;
    if (!tx_busy_q) begin
      if (data_en) begin
        tx_shift_d = {1'b1, tx_data, 1'b0};
        tx_busy_d  = 1'b1;
        tx_cnt_d   = '0;
        tx_bits_d  = '0;
      end
    end else if (tx_cnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
      tx_cnt_d   = '0;
      tx_shift_d = {1'b1, tx_shift_q[TX_DATA_WIDTH+1:1]};
      if (tx_bits_q == TBW'(TX_DATA_WIDTH + 1)) tx_busy_d = 1'b0;
      else tx_bits_d = tx_bits_q + 1'b1;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  // Receiver: detect start, re-check it mid-bit, shift data, validate stop.
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], rx};
    rx_cnt_d   = rx_cnt_q;
    rx_bits_d  = rx_bits_q;
    rx_act_d   = rx_act_q;
    rx_shift_d = rx_shift_q;
    rx_ready_d = 1'b0;
    if (!rx_act_q) begin
      if (!rx_s) begin
        rx_act_d  = 1'b1;
        rx_cnt_d  = CW'(HALF);
        rx_bits_d = '0;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = CW'(CLOCKS_PER_PULSE - 1);
      if (rx_bits_q == '0) begin
        if (rx_s) rx_act_d = 1'b0;
        else rx_bits_d = RBW'(1);
      end else if (rx_bits_q == RBW'(RX_DATA_WIDTH + 1)) begin
        rx_act_d   = 1'b0;
        rx_ready_d = rx_s;
      end else begin
        rx_shift_d = {rx_s, rx_shift_q[RX_DATA_WIDTH-1:1]};
        rx_bits_d  = rx_bits_q + 1'b1;
      end
    end
  end

  // State registers; the line idles high out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
      rx_sync_q  <= '1;
      rx_cnt_q   <= '0;
      rx_bits_q  <= '0;
      rx_act_q   <= 1'b0;
      rx_shift_q <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_busy_q  <= tx_busy_d;
      rx_sync_q  <= rx_sync_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_act_q   <= rx_act_d;
      rx_shift_q <= rx_shift_d;
      rx_ready_q <= rx_ready_d;
    end
  end

endmodule

// File: rtl/bus_bridge_master.sv
// Remote bridge end: replays UART request frames as serial-bus master transactions.
// Latency: first address bit one cycle after sready; read reply sent once the byte is assembled.
// Backpressure: one pending frame is buffered; a frame arriving while it is full is dropped (ovf).
module bus_bridge_master
  import bus_bridge_pkg::*;
#(
  parameter int DATA_WIDTH            = 8,
  parameter int ADDR_WIDTH            = 12,
  parameter int UART_CLOCKS_PER_PULSE = 5208,
  parameter int RD_TIMEOUT            = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic u_rx,
  output logic u_tx,
  output logic mbreq,
  input  logic mbgrant,
  output logic mwdata,
  output logic mmode,
  output logic mvalid,
  input  logic sready,
  input  logic mrdata,
  input  logic svalid,
  output logic ovf
);

  localparam int FW       = frame_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int MODE_BIT = mode_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int MAXW     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BCW      = $clog2(MAXW + 1);
  localparam int TCW      = $clog2(RD_TIMEOUT + 1);
  localparam int IW       = $clog2(FW);

  bb_state_e             state_q, state_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [FW-1:0]         pend_dat_q, pend_dat_d, work_q, work_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  mvalid_q, mvalid_d, mwdata_q, mwdata_d, mmode_q, mmode_d;
  logic                  ovf_q, ovf_d, utx_sent_q, utx_sent_d;
  logic                  consume;
  logic [IW-1:0]         bit_idx;
  logic [FW-1:0]         rx_frame;
  logic                  rx_rdy, tx_busy, data_en;

  assign mbreq   = (state_q != ST_IDLE) && (state_q != ST_UTX);
  assign mvalid  = mvalid_q;
  assign mwdata  = mwdata_q;
  assign mmode   = mmode_q;
  assign ovf     = ovf_q;
  assign data_en = (state_q == ST_UTX) && !utx_sent_q;

  uart #(
    .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
    .TX_DATA_WIDTH   (DATA_WIDTH),
    .RX_DATA_WIDTH   (FW)
  ) u_uart (
    .clk     (clk),
    .rstn    (~rst),
    .data_en (data_en),
    .tx_data (rd_q),
    .tx_busy (tx_busy),
    .tx      (u_tx),
    .rx      (u_rx),
    .rx_data (rx_frame),
    .rx_ready(rx_rdy)
  );

  // Transaction FSM, serial shifters and the single-entry pending buffer.
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    work_d     = work_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rd_d       = rd_q;
    utx_sent_d = utx_sent_q;
    mvalid_d   = 1'b0;
    mwdata_d   = 1'b0;
    mmode_d    = MODE_READ;
    ovf_d      = 1'b0;
    consume    = 1'b0;
    bit_idx    = '0;
    case (state_q)
      ST_IDLE: if (pend_vld_q) begin
        consume   = 1'b1;
        work_d    = pend_dat_q;
        state_d   = ST_REQ;
        bit_cnt_d = '0;
      end
      ST_REQ: if (mbgrant) begin
        state_d   = ST_WAIT_RDY;
        bit_cnt_d = '0;
      end
      // Outputs are registered, so bit 0 is staged here to appear on ADDR's first cycle.
      ST_WAIT_RDY: if (sready) begin
        state_d   = ST_ADDR;
        bit_cnt_d = '0;
        mvalid_d  = 1'b1;
        mwdata_d  = work_q[0];
        mmode_d   = work_q[MODE_BIT];
      end
      ST_ADDR: begin
        mvalid_d  = 1'b1;
        mmode_d   = work_q[MODE_BIT];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BCW'(ADDR_WIDTH - 1)) begin
          bit_cnt_d = '0;
          if (work_q[MODE_BIT] == MODE_WRITE) begin
            state_d  = ST_WDATA;
            mwdata_d = work_q[ADDR_WIDTH];
          end else begin
            state_d   = ST_RWAIT;
            mvalid_d  = 1'b0;
            mmode_d   = MODE_READ;
            tmo_cnt_d = '0;
          end
        end else begin
          bit_idx  = IW'(bit_cnt_q) + IW'(1);
          mwdata_d = work_q[bit_idx];
        end
      end
      ST_WDATA: begin
        mvalid_d  = 1'b1;
        mmode_d   = MODE_WRITE;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          mvalid_d  = 1'b0;
          mmode_d   = MODE_READ;
        end else begin
          bit_idx  = IW'(ADDR_WIDTH) + IW'(bit_cnt_q) + IW'(1);
          mwdata_d = work_q[bit_idx];
        end
      end
      // Read data arrives LSB first and is shifted in from the top.
      ST_RWAIT: begin
        if (svalid) begin
          rd_d      = {mrdata, rd_q[DATA_WIDTH-1:1]};
          state_d   = ST_RDATA;
          bit_cnt_d = '0;
        end else if (tmo_cnt_q == TCW'(RD_TIMEOUT - 1)) begin
          rd_d       = '1;
          state_d    = ST_UTX;
          bit_cnt_d  = '0;
          utx_sent_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_RDATA: if (svalid) begin
        rd_d      = {mrdata, rd_q[DATA_WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BCW'(DATA_WIDTH - 2)) begin
          state_d    = ST_UTX;
          bit_cnt_d  = '0;
          utx_sent_d = 1'b0;
        end
      end
      ST_UTX: begin
        if (!utx_sent_q) begin
          if (tx_busy) utx_sent_d = 1'b1;
        end else if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A frame landing on the consume cycle refills the buffer instead of being dropped.
    if (rx_rdy) begin
      if (!pend_vld_q || consume) begin
        pend_vld_d = 1'b1;
        pend_dat_d = rx_frame;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (consume) begin
      pend_vld_d = 1'b0;
    end
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      work_q     <= '0;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      rd_q       <= '0;
      utx_sent_q <= 1'b0;
      mvalid_q   <= 1'b0;
      mwdata_q   <= 1'b0;
      mmode_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      work_q     <= work_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rd_q       <= rd_d;
      utx_sent_q <= utx_sent_d;
      mvalid_q   <= mvalid_d;
      mwdata_q   <= mwdata_d;
      mmode_q    <= mmode_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bus_bridge_master.sv
// Directed bench: a uart drives request frames, the bench plays arbiter and serial slave.
// Expected values are hand-computed constants from the frame contents.
// Ends with a single TB_RESULT summary line.
module tb_bus_bridge_master;

  localparam int DW  = 8;
  localparam int AW  = 12;
  localparam int CPP = 8;
  localparam int RDT = 40;
  localparam int FW  = AW + DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic u_rx, u_tx, mbreq, mbgrant, mwdata, mmode, mvalid, sready, mrdata, svalid, ovf;

  logic          tb_tx_en;
  logic [FW-1:0] tb_tx_dat;
  logic          tb_tx_busy;
  logic [DW-1:0] tb_rx_dat;
  logic          tb_rx_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]    bitq[$];
  logic [DW-1:0] replyq[$];
  int ovf_cnt   = 0;
  int utx_low   = 0;

  always #5 clk = ~clk;

  bus_bridge_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UART_CLOCKS_PER_PULSE(CPP), .RD_TIMEOUT(RDT)
  ) dut (
    .clk(clk), .rst(rst), .u_rx(u_rx), .u_tx(u_tx), .mbreq(mbreq), .mbgrant(mbgrant),
    .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid), .sready(sready), .mrdata(mrdata),
    .svalid(svalid), .ovf(ovf)
  );

  uart #(.CLOCKS_PER_PULSE(CPP), .TX_DATA_WIDTH(FW), .RX_DATA_WIDTH(DW)) u_tb_uart (
    .clk(clk), .rstn(~rst), .data_en(tb_tx_en), .tx_data(tb_tx_dat), .tx_busy(tb_tx_busy),
    .tx(u_rx), .rx(u_tx), .rx_data(tb_rx_dat), .rx_ready(tb_rx_rdy)
  );

  // Observers, sampled away from the active edge.
  always @(negedge clk) begin
    if (mvalid) bitq.push_back({mmode, mwdata});
    if (ovf) ovf_cnt++;
    if (!u_tx) utx_low++;
  end

  always @(posedge clk) if (tb_rx_rdy) replyq.push_back(tb_rx_dat);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (tb_tx_busy && n < 1000) begin @(negedge clk); n++; end
    tb_tx_dat = {mode, d, a};
    tb_tx_en  = 1'b1;
    @(negedge clk);
    tb_tx_en  = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (tb_tx_busy && n < 1000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_mbreq(input logic v, input string tag, input int budget);
    int n = 0;
    while (mbreq !== v && n < budget) begin @(negedge clk); n++; end
    chk(tag, 32'(mbreq), 32'(v));
  endtask

  task automatic wait_reply(input int cnt, input string tag);
    int n = 0;
    while (replyq.size() < cnt && n < 600) begin @(negedge clk); n++; end
    chk(tag, 32'(replyq.size()), 32'(cnt));
  endtask

  function automatic logic [31:0] last_reply();
    if (replyq.size() == 0) return 32'hDEAD;
    return 32'(replyq[replyq.size()-1]);
  endfunction

  // Grant and ready, then follow the address phase until mvalid drops.
  task automatic run_addr_phase(input string tag);
    int n = 0;
    mbgrant = 1'b1;
    sready  = 1'b1;
    while (mvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_mvalid_rise"}, 32'(mvalid), 32'd1);
    n = 0;
    while (mvalid !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_mvalid_fall"}, 32'(mvalid), 32'd0);
    mbgrant = 1'b0;
    sready  = 1'b0;
  endtask

  task automatic slave_send(input logic [DW-1:0] b, input int gap_at, input int gap_len);
    for (int i = 0; i < DW; i++) begin
      if (i == gap_at) begin
        svalid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      svalid = 1'b1;
      mrdata = b[i];
      @(negedge clk);
    end
    svalid = 1'b0;
    mrdata = 1'b0;
  endtask

  task automatic bits_val(input int start, input int n, output logic [31:0] v, output int m);
    v = '0;
    m = 0;
    for (int i = 0; i < n; i++) begin
      if (start + i < bitq.size()) begin
        v[i] = bitq[start+i][0];
        m += int'(bitq[start+i][1]);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int m, n, low0, nrep0, ovf0;
    tb_tx_en = 1'b0; tb_tx_dat = '0;
    mbgrant = 1'b0; sready = 1'b0; mrdata = 1'b0; svalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mbreq",  32'(mbreq),  32'd0);
    chk("rst_mvalid", 32'(mvalid), 32'd0);
    chk("rst_mwdata", 32'(mwdata), 32'd0);
    chk("rst_mmode",  32'(mmode),  32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);
    chk("rst_u_tx",   32'(u_tx),   32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: write 0x9AA <- 0xD5
    bitq.delete();
    low0 = utx_low; nrep0 = replyq.size();
    send_frame(1'b1, 12'h9AA, 8'hD5);
    wait_mbreq(1'b1, "t1_mbreq", 600);
    chk("t1_mvalid_pre", 32'(mvalid), 32'd0);
    mbgrant = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_no_bits_before_rdy", 32'(mvalid), 32'd0);
    sready = 1'b1;
    @(negedge clk);
    chk("t1_first_bit_latency", 32'(mvalid), 32'd1);
    chk("t1_first_bit", 32'(mwdata), 32'd0);
    wait_mbreq(1'b0, "t1_done", 100);
    mbgrant = 1'b0; sready = 1'b0;
    chk("t1_nbits", 32'(bitq.size()), 32'd20);
    bits_val(0, 20, v, m);
    chk("t1_bits", v, 32'h000D59AA);
    chk("t1_mmode_cnt", 32'(m), 32'd20);
    repeat (150) @(negedge clk);
    chk("t1_no_utx", 32'(utx_low - low0), 32'd0);
    chk("t1_no_reply", 32'(replyq.size()), 32'(nrep0));

    // 2: read 0x9AA, slave returns 0xD4 after 5 cycles
    bitq.delete();
    nrep0 = replyq.size();
    send_frame(1'b0, 12'h9AA, 8'h00);
    wait_mbreq(1'b1, "t2_mbreq", 600);
    run_addr_phase("t2");
    chk("t2_nbits", 32'(bitq.size()), 32'd12);
    bits_val(0, 12, v, m);
    chk("t2_addr", v, 32'h9AA);
    chk("t2_mmode_cnt", 32'(m), 32'd0);
    repeat (5) @(negedge clk);
    slave_send(8'hD4, -1, 0);
    wait_reply(nrep0 + 1, "t2_reply_cnt");
    chk("t2_reply", last_reply(), 32'hD4);
    chk("t2_mbreq_low", 32'(mbreq), 32'd0);
    repeat (60) @(negedge clk);

    // 3: read with silent slave -> timeout reply 0xFF
    nrep0 = replyq.size();
    send_frame(1'b0, 12'h123, 8'h00);
    wait_mbreq(1'b1, "t3_mbreq", 600);
    run_addr_phase("t3");
    n = 0;
    while (mbreq !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("t3_timeout_cycles", 32'(n), 32'(RDT));
    wait_reply(nrep0 + 1, "t3_reply_cnt");
    chk("t3_reply", last_reply(), 32'hFF);
    repeat (60) @(negedge clk);

    // 4: three back-to-back frames while grant is withheld
    bitq.delete();
    ovf0 = ovf_cnt;
    send_frame(1'b1, 12'h011, 8'h22);
    send_frame(1'b1, 12'h033, 8'h44);
    send_frame(1'b1, 12'h055, 8'h66);
    wait_tx_idle();
    chk("t4_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
    chk("t4_stalled_mbreq", 32'(mbreq), 32'd1);
    mbgrant = 1'b1; sready = 1'b1;
    repeat (300) @(negedge clk);
    mbgrant = 1'b0; sready = 1'b0;
    chk("t4_nbits", 32'(bitq.size()), 32'd40);
    bits_val(0, 20, v, m);
    chk("t4_first", v, 32'h00022011);
    bits_val(20, 20, v, m);
    chk("t4_second", v, 32'h00044033);

    // 5: svalid gap of 3 cycles mid-RDATA
    nrep0 = replyq.size();
    send_frame(1'b0, 12'h0F0, 8'h00);
    wait_mbreq(1'b1, "t5_mbreq", 600);
    run_addr_phase("t5");
    repeat (2) @(negedge clk);
    slave_send(8'hA5, 4, 3);
    wait_reply(nrep0 + 1, "t5_reply_cnt");
    chk("t5_reply", last_reply(), 32'hA5);
    repeat (60) @(negedge clk);

    // 6: reset during ADDR, then a clean read
    send_frame(1'b1, 12'h7FF, 8'h81);
    wait_mbreq(1'b1, "t6_mbreq", 600);
    mbgrant = 1'b1; sready = 1'b1;
    n = 0;
    while (mvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("t6_pre_mwdata", 32'(mwdata), 32'd1);
    chk("t6_pre_mmode", 32'(mmode), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_mbreq",  32'(mbreq),  32'd0);
    chk("t6_rst_mvalid", 32'(mvalid), 32'd0);
    chk("t6_rst_mwdata", 32'(mwdata), 32'd0);
    chk("t6_rst_mmode",  32'(mmode),  32'd0);
    chk("t6_rst_u_tx",   32'(u_tx),   32'd1);
    mbgrant = 1'b0; sready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nrep0 = replyq.size();
    low0 = utx_low;
    repeat (200) @(negedge clk);
    chk("t6_no_stale_reply", 32'(replyq.size()), 32'(nrep0));
    chk("t6_no_utx", 32'(utx_low - low0), 32'd0);
    send_frame(1'b0, 12'h456, 8'h00);
    wait_mbreq(1'b1, "t6_mbreq2", 600);
    run_addr_phase("t6");
    @(negedge clk);
    slave_send(8'h3C, -1, 0);
    wait_reply(nrep0 + 1, "t6_reply_cnt");
    chk("t6_reply", last_reply(), 32'h3C);
    repeat (60) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
